// File: rtl/interp_line_writer_if.sv
// -----------------------------------------------------------------------------
// interp_line_writer_if
// Pixel stream bundle feeding the interpolation line writer.
//   frame_start : one-cycle pulse marking a new frame
//   pix_de      : pixel valid; one contiguous high run is one line
//   pix_data    : pixel value, meaningful while pix_de is high
// master = pixel source, slave = line writer.
// -----------------------------------------------------------------------------
interface interp_line_writer_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  frame_start;
    logic                  pix_de;
    logic [DATA_WIDTH-1:0] pix_data;

    modport master (
        output frame_start,
        output pix_de,
        output pix_data
    );

    modport slave (
        input  frame_start,
        input  pix_de,
        input  pix_data
    );
endinterface

// File: rtl/interp_line_writer.sv
// -----------------------------------------------------------------------------
// interp_line_writer
// Converts a DE-qualified pixel stream into line-granular writes to two
// ping-pong line RAMs and tracks which buffer holds a complete line.
// Lines arriving while the target buffer is still owned by the reader are
// dropped and flagged.
//
// Ports:
//   wr_clk       : write clock, all logic on rising edge
//   tb_wr_rst    : asynchronous active-high reset
//   pix          : pixel stream (frame_start, pix_de, pix_data)
//   buf_release  : per-buffer release pulse from the reader
//   ram_wr_en    : write enable RAM0 (bit 0) / RAM1 (bit 1), one-hot or zero
//   ram_wr_addr  : shared write address
//   ram_wr_data  : shared write data
//   line_ready   : bit i = buffer i holds a complete, unreleased line
//   line_cnt     : lines committed since last frame_start, saturating
//   len_err      : one-cycle pulse, committed line length != LINE_WIDTH
//   overflow     : sticky, a line was dropped; cleared only by reset
// -----------------------------------------------------------------------------
module interp_line_writer #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 1280
) (
    input  logic                   wr_clk,
    input  logic                   tb_wr_rst,
    interp_line_writer_if.slave    pix,
    input  logic [1:0]             buf_release,
    output logic [1:0]             ram_wr_en,
    output logic [ADDR_WIDTH-1:0]  ram_wr_addr,
    output logic [DATA_WIDTH-1:0]  ram_wr_data,
    output logic [1:0]             line_ready,
    output logic [11:0]            line_cnt,
    output logic                   len_err,
    output logic                   overflow
);

    localparam int unsigned IDX_W = 12;
    localparam int unsigned CNT_W = 12;
    localparam logic [IDX_W-1:0] IDX_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LINE_LEN = IDX_W'(LINE_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state;
    logic             de_d;
    logic             wr_sel;
    logic [IDX_W-1:0] pix_idx;

    logic       line_start_c;
    logic       line_end_c;
    logic       commit_c;
    logic [1:0] sel_mask_c;
    logic [1:0] commit_mask_c;

    // DE edge detection against the one-cycle delayed copy
    assign line_start_c = pix.pix_de & ~de_d;
    assign line_end_c   = ~pix.pix_de & de_d;

    // A line end in FILL commits unless a frame_start aborts it in the same cycle
    assign commit_c      = (state == FILL) & line_end_c & ~pix.frame_start;
    assign sel_mask_c    = wr_sel ? 2'b10 : 2'b01;
    assign commit_mask_c = commit_c ? sel_mask_c : 2'b00;

    // Line writer FSM with registered RAM port and status outputs
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state       <= IDLE;
            de_d        <= 1'b0;
            wr_sel      <= 1'b0;
            pix_idx     <= '0;
            ram_wr_en   <= '0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            line_ready  <= '0;
            line_cnt    <= '0;
            len_err     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            de_d      <= pix.pix_de;
            ram_wr_en <= '0;
            len_err   <= 1'b0;

            // Release and commit can hit different buffers in the same cycle;
            // a commit target is never ready, so releasing it is a no-op.
            line_ready <= (line_ready & ~buf_release) | commit_mask_c;

            if (pix.frame_start) begin
                line_cnt <= '0;
            end else if (commit_c && (line_cnt != CNT_MAX)) begin
                line_cnt <= line_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (line_start_c) begin
                        if (!line_ready[wr_sel]) begin
                            state       <= FILL;
                            ram_wr_en   <= sel_mask_c;
                            ram_wr_addr <= '0;
                            ram_wr_data <= pix.pix_data;
                            pix_idx     <= IDX_W'(1);
                        end else begin
                            state    <= DROP;
                            overflow <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    if (pix.frame_start) begin
                        // Abort: buffer stays not-ready, wr_sel unchanged
                        state <= IDLE;
                    end else if (pix.pix_de) begin
                        // Pixels past the line length are counted but not written
                        if (pix_idx < LINE_LEN) begin
                            ram_wr_en   <= sel_mask_c;
                            ram_wr_addr <= ADDR_WIDTH'(pix_idx);
                            ram_wr_data <= pix.pix_data;
                        end
                        if (pix_idx != IDX_MAX) begin
                            pix_idx <= pix_idx + IDX_W'(1);
                        end
                    end else if (line_end_c) begin
                        state   <= IDLE;
                        wr_sel  <= ~wr_sel;
                        len_err <= (pix_idx != LINE_LEN);
                    end
                end

                DROP: begin
                    if (pix.frame_start || line_end_c) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interp_line_writer.sv
`timescale 1ns/1ps
module tb_interp_line_writer;

    localparam int unsigned ADDR_WIDTH = 11;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned LINE_WIDTH = 1280;
    localparam int          NVEC       = 10;

    logic                  wr_clk = 1'b0;
    logic                  tb_wr_rst;
    logic [1:0]            buf_release;
    logic [1:0]            ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [1:0]            line_ready;
    logic [11:0]           line_cnt;
    logic                  len_err;
    logic                  overflow;

    interp_line_writer_if #(.DATA_WIDTH(DATA_WIDTH)) pix_if ();

    interp_line_writer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) dut (
        .wr_clk      (wr_clk),
        .tb_wr_rst   (tb_wr_rst),
        .pix         (pix_if),
        .buf_release (buf_release),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .line_ready  (line_ready),
        .line_cnt    (line_cnt),
        .len_err     (len_err),
        .overflow    (overflow)
    );

    always #5 wr_clk = ~wr_clk;

    int checks = 0;
    int errors = 0;

    // Written only by the driver
    int          line_id   = 0;
    logic [15:0] line_seed = 16'd0;

    // Written only by the write monitor
    int mon_id     = 0;
    int exp_addr   = 0;
    int wr_cnt0    = 0;
    int wr_cnt1    = 0;
    int seq_err    = 0;
    int lerr_cnt   = 0;

    // Write monitor: counts writes per buffer, checks sequential address and data
    always @(negedge wr_clk) begin
        if (!tb_wr_rst) begin
            if (mon_id != line_id) begin
                mon_id   = line_id;
                exp_addr = 0;
            end
            if (ram_wr_en != 2'b00) begin
                if (ram_wr_en == 2'b11)      seq_err++;
                else if (ram_wr_en == 2'b01) wr_cnt0++;
                else                         wr_cnt1++;
                if (ram_wr_addr != ADDR_WIDTH'(exp_addr) ||
                    ram_wr_data != 16'(int'(line_seed) + exp_addr))
                    seq_err++;
                exp_addr++;
            end
            if (len_err) lerr_cnt++;
        end
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_line(input int n, input int fs_at, input logic [15:0] seed,
                             input logic [1:0] rel_end, input logic [1:0] exp_buf,
                             input bit do_end);
        line_seed = seed;
        line_id++;
        for (int i = 0; i < n; i++) begin
            pix_if.pix_de      = 1'b1;
            pix_if.pix_data    = seed + 16'(i);
            pix_if.frame_start = (i == fs_at);
            tick();
            pix_if.frame_start = 1'b0;
            if (i == 0) begin
                chk("first_wr_en", int'(ram_wr_en), int'(exp_buf));
                if (exp_buf != 2'b00) chk("first_wr_addr", int'(ram_wr_addr), 0);
                else                  chk("drop_overflow", int'(overflow), 1);
            end
        end
        if (do_end) begin
            pix_if.pix_de = 1'b0;
            buf_release   = rel_end;
            tick();
            buf_release   = 2'b00;
        end
    endtask

    typedef struct {
        int         n;
        int         fs_at;
        logic [1:0] rel;
        logic [1:0] rel_ready;
        logic [1:0] rel_end;
        logic [1:0] buf_sel;
        int         writes;
        logic [1:0] ready;
        int         cnt;
        logic       lerr;
        logic       ovf;
    } vec_t;

    vec_t vecs [NVEC];

    initial begin
        vec_t v;
        int   w0, w1, s0, l0;

        //            n     fs   rel    relrdy relend buf    wr    ready  cnt lerr  ovf
        vecs[0] = '{1280,  -1, 2'b00, 2'b00, 2'b00, 2'b01, 1280, 2'b01, 1, 1'b0, 1'b0};
        vecs[1] = '{1280,  -1, 2'b00, 2'b00, 2'b00, 2'b10, 1280, 2'b11, 2, 1'b0, 1'b0};
        vecs[2] = '{1280,  -1, 2'b00, 2'b00, 2'b00, 2'b00,    0, 2'b11, 2, 1'b0, 1'b1};
        vecs[3] = '{1280,  -1, 2'b01, 2'b10, 2'b00, 2'b01, 1280, 2'b11, 3, 1'b0, 1'b1};
        vecs[4] = '{ 100,  -1, 2'b10, 2'b01, 2'b00, 2'b10,  100, 2'b11, 4, 1'b1, 1'b1};
        vecs[5] = '{1300,  -1, 2'b01, 2'b10, 2'b00, 2'b01, 1280, 2'b11, 5, 1'b1, 1'b1};
        vecs[6] = '{1280, 500, 2'b10, 2'b01, 2'b00, 2'b10,  500, 2'b01, 0, 1'b0, 1'b1};
        vecs[7] = '{1280,  -1, 2'b00, 2'b00, 2'b00, 2'b10, 1280, 2'b11, 1, 1'b0, 1'b1};
        vecs[8] = '{1280,  -1, 2'b01, 2'b10, 2'b10, 2'b01, 1280, 2'b01, 2, 1'b0, 1'b1};
        vecs[9] = '{  64,  -1, 2'b00, 2'b00, 2'b00, 2'b10,   64, 2'b11, 3, 1'b1, 1'b1};

        tb_wr_rst          = 1'b1;
        buf_release        = 2'b00;
        pix_if.frame_start = 1'b0;
        pix_if.pix_de      = 1'b0;
        pix_if.pix_data    = '0;
        #2;
        chk("reset_wr_en",   int'(ram_wr_en),   0);
        chk("reset_addr",    int'(ram_wr_addr), 0);
        chk("reset_data",    int'(ram_wr_data), 0);
        chk("reset_ready",   int'(line_ready),  0);
        chk("reset_cnt",     int'(line_cnt),    0);
        chk("reset_len_err", int'(len_err),     0);
        chk("reset_ovf",     int'(overflow),    0);
        tick();
        tick();
        tb_wr_rst = 1'b0;
        tick();

        // Table-driven line sequence
        for (int k = 0; k < NVEC; k++) begin
            v = vecs[k];
            if (v.rel != 2'b00) begin
                buf_release = v.rel;
                tick();
                buf_release = 2'b00;
                chk($sformatf("v%0d_rel_ready", k), int'(line_ready), int'(v.rel_ready));
            end
            w0 = wr_cnt0; w1 = wr_cnt1; s0 = seq_err; l0 = lerr_cnt;
            send_line(v.n, v.fs_at, 16'(k * 4096 + 7), v.rel_end, v.buf_sel, 1'b1);
            chk($sformatf("v%0d_ready", k),   int'(line_ready), int'(v.ready));
            chk($sformatf("v%0d_cnt", k),     int'(line_cnt),   v.cnt);
            chk($sformatf("v%0d_len_err", k), int'(len_err),    int'(v.lerr));
            chk($sformatf("v%0d_ovf", k),     int'(overflow),   int'(v.ovf));
            tick();
            chk($sformatf("v%0d_len_err_drop", k), int'(len_err), 0);
            chk($sformatf("v%0d_writes0", k), wr_cnt0 - w0, (v.buf_sel == 2'b01) ? v.writes : 0);
            chk($sformatf("v%0d_writes1", k), wr_cnt1 - w1, (v.buf_sel == 2'b10) ? v.writes : 0);
            chk($sformatf("v%0d_seq", k),     seq_err - s0, 0);
            chk($sformatf("v%0d_pulses", k),  lerr_cnt - l0, v.lerr ? 1 : 0);
        end

        // Reset asserted between edges in the middle of a line
        buf_release = 2'b11;
        tick();
        buf_release = 2'b00;
        chk("rst_pre_ready", int'(line_ready), 0);
        send_line(700, -1, 16'h5000, 2'b00, 2'b01, 1'b0);
        #3;
        tb_wr_rst     = 1'b1;
        pix_if.pix_de = 1'b0;
        #1;
        chk("rst_wr_en",   int'(ram_wr_en),   0);
        chk("rst_addr",    int'(ram_wr_addr), 0);
        chk("rst_data",    int'(ram_wr_data), 0);
        chk("rst_ready",   int'(line_ready),  0);
        chk("rst_cnt",     int'(line_cnt),    0);
        chk("rst_len_err", int'(len_err),     0);
        chk("rst_ovf",     int'(overflow),    0);
        tick();
        tick();
        #3;
        tb_wr_rst = 1'b0;
        w0 = wr_cnt0; w1 = wr_cnt1;
        repeat (5) tick();
        chk("rst_idle_writes", (wr_cnt0 - w0) + (wr_cnt1 - w1), 0);
        w0 = wr_cnt0; s0 = seq_err;
        send_line(1280, -1, 16'h6000, 2'b00, 2'b01, 1'b1);
        chk("post_rst_ready", int'(line_ready), 1);
        chk("post_rst_cnt",   int'(line_cnt),   1);
        chk("post_rst_ovf",   int'(overflow),   0);
        tick();
        chk("post_rst_writes0", wr_cnt0 - w0, 1280);
        chk("post_rst_seq",     seq_err - s0, 0);

        // Back-to-back lines separated by a single DE-low cycle
        buf_release = 2'b01;
        tick();
        buf_release = 2'b00;
        chk("b2b_pre_ready", int'(line_ready), 0);
        w0 = wr_cnt0; w1 = wr_cnt1; s0 = seq_err; l0 = lerr_cnt;
        send_line(40, -1, 16'h7000, 2'b00, 2'b10, 1'b1);
        send_line(40, -1, 16'h7100, 2'b00, 2'b01, 1'b1);
        chk("b2b_ready",   int'(line_ready), 3);
        chk("b2b_cnt",     int'(line_cnt),   3);
        chk("b2b_len_err", int'(len_err),    1);
        tick();
        chk("b2b_writes0", wr_cnt0 - w0, 40);
        chk("b2b_writes1", wr_cnt1 - w1, 40);
        chk("b2b_seq",     seq_err - s0, 0);
        chk("b2b_pulses",  lerr_cnt - l0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
